// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-port RAM arbiter.
//   ram_arb_state_t : arbiter FSM state (IDLE, ACCESS, ACK)
//   PORT_IFETCH/PORT_DATA : port indices; NUM_PORTS : requester count
//   port_onehot()   : one-hot port vector from a 1-bit port index
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } ram_arb_state_t;

  localparam int unsigned PORT_IFETCH = 0;
  localparam int unsigned PORT_DATA   = 1;
  localparam int unsigned NUM_PORTS   = 2;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester grant logic for ram_arbiter.
//   Build option: RAM_ARB_ROUND_ROBIN_EN
//     defined   -> round-robin; a registered pointer names the favoured port
//                  on a tie and toggles on every grant.
//     undefined -> fixed priority, port 1 (data) wins ties; no pointer state.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset (pointer only)
//   i_req[1:0]   : raw requests
//   i_mask[1:0]  : requests to ignore this cycle
//   i_advance    : 1 when the caller consumes a grant this cycle (if valid)
//   o_valid      : some unmasked request exists
//   o_grant      : winning port index (meaningful when o_valid=1)
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  input  logic       i_advance,
  output logic       o_valid,
  output logic       o_grant
);

  logic [1:0] w_eligible;

  assign w_eligible = i_req & ~i_mask;
  assign o_valid    = |w_eligible;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic r_ptr;

  always_comb begin
    o_grant = w_eligible[1];
    if (&w_eligible) o_grant = r_ptr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (i_advance && o_valid) begin
      r_ptr <= ~r_ptr;
    end
  end
`else
  logic w_unused_fixed;

  // Port 1 wins whenever it is eligible, otherwise port 0.
  assign o_grant        = w_eligible[1];
  assign w_unused_fixed = ^{i_clk, i_rst, i_advance};
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: time-shares a single-port, byte-maskable RAM with 1-cycle read
// latency between port 0 (instruction fetch) and port 1 (load/store).
//   Build option: RAM_ARB_ROUND_ROBIN_EN (round-robin ties; default is fixed
//   priority with port 1 winning ties).
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   pN_req/wr/wr_mask/addr/wdata : request payload, held until pN_ack
//   pN_rdata, pN_ack          : read data (0 unless acked), 1-cycle completion
//   ram_wr/wr_mask/addr/data_in : RAM drive, muxed from the owning port
//   ram_data_out              : RAM registered read data
//   busy                      : 1 while not IDLE
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req,
  input  logic                 p0_wr,
  input  logic [3:0]           p0_wr_mask,
  input  logic [ADDR_BITS-1:0] p0_addr,
  input  logic [31:0]          p0_wdata,
  output logic [31:0]          p0_rdata,
  output logic                 p0_ack,
  input  logic                 p1_req,
  input  logic                 p1_wr,
  input  logic [3:0]           p1_wr_mask,
  input  logic [ADDR_BITS-1:0] p1_addr,
  input  logic [31:0]          p1_wdata,
  output logic [31:0]          p1_rdata,
  output logic                 p1_ack,
  output logic                 ram_wr,
  output logic [3:0]           ram_wr_mask,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_data_in,
  input  logic [31:0]          ram_data_out,
  output logic                 busy
);

  ram_arb_state_t       r_state;
  logic                 r_owner;
  logic [NUM_PORTS-1:0] r_ack;
  logic                 r_busy;

  logic [NUM_PORTS-1:0] w_mask;
  logic                 w_arb_phase;
  logic                 w_grant_valid;
  logic                 w_grant;
  logic                 w_owner_wr;

  // In ACK the owner's req is still high; masking it lets the other port
  // take the next slot instead of the same request being granted twice.
  assign w_mask      = (r_state == ACK) ? port_onehot(r_owner) : '0;
  assign w_arb_phase = (r_state == IDLE) || (r_state == ACK);

  rr_arbiter2 u_arb (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     ({p1_req, p0_req}),
    .i_mask    (w_mask),
    .i_advance (w_arb_phase),
    .o_valid   (w_grant_valid),
    .o_grant   (w_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= '0;
          if (w_grant_valid) begin
            r_owner <= w_grant;
            r_state <= ACCESS;
            r_busy  <= 1'b1;
          end
        end
        ACCESS: begin
          r_ack   <= port_onehot(r_owner);
          r_state <= ACK;
          r_busy  <= 1'b1;
        end
        ACK: begin
          r_ack <= '0;
          if (w_grant_valid) begin
            r_owner <= w_grant;
            r_state <= ACCESS;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_ack   <= '0;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ram_addr    = r_owner ? p1_addr    : p0_addr;
    ram_data_in = r_owner ? p1_wdata   : p0_wdata;
    ram_wr_mask = r_owner ? p1_wr_mask : p0_wr_mask;
    w_owner_wr  = r_owner ? p1_wr      : p0_wr;
  end

  // rst gates the write and the ack directly so a reset landing in ACCESS
  // or ACK takes effect in that same cycle.
  assign ram_wr   = (r_state == ACCESS) && w_owner_wr && !rst;
  assign p0_ack   = r_ack[PORT_IFETCH] && !rst;
  assign p1_ack   = r_ack[PORT_DATA] && !rst;
  assign p0_rdata = p0_ack ? ram_data_out : '0;
  assign p1_rdata = p1_ack ? ram_data_out : '0;
  assign busy     = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = '0;
  logic [1:0]    wr  = '0;
  logic [3:0]    wmask [2];
  logic [AW-1:0] addr  [2];
  logic [31:0]   wdata [2];
  logic [31:0]   rdata0, rdata1;
  logic          ack0, ack1;
  logic          ram_wr;
  logic [3:0]    ram_wr_mask;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_di;
  logic [31:0]   ram_do = '0;
  logic          busy;

  logic [31:0]   mem [0:1023];
  logic [31:0]   sm  [0:1023];

  int errors = 0;
  int checks = 0;
  logic done0 = 1'b0;
  logic done1 = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_BITS(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_req       (req[0]),
    .p0_wr        (wr[0]),
    .p0_wr_mask   (wmask[0]),
    .p0_addr      (addr[0]),
    .p0_wdata     (wdata[0]),
    .p0_rdata     (rdata0),
    .p0_ack       (ack0),
    .p1_req       (req[1]),
    .p1_wr        (wr[1]),
    .p1_wr_mask   (wmask[1]),
    .p1_addr      (addr[1]),
    .p1_wdata     (wdata[1]),
    .p1_rdata     (rdata1),
    .p1_ack       (ack1),
    .ram_wr       (ram_wr),
    .ram_wr_mask  (ram_wr_mask),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_di),
    .ram_data_out (ram_do),
    .busy         (busy)
  );

  // RAM: registered read of the addressed word (pre-write value), masked write.
  always @(posedge clk) begin
    ram_do <= mem[ram_addr];
    if (ram_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (ram_wr_mask[k]) mem[ram_addr][8*k +: 8] = ram_di[8*k +: 8];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    chk("reset_flags", {28'd0, ack0, ack1, busy, ram_wr}, 32'd0);
    chk("reset_rdata", rdata0 | rdata1, 32'd0);
    chk("reset_addr_port0", 32'(ram_addr), 32'(addr[0]));
    rst = 1'b0;
  endtask

  task automatic do_txn(input int n, input logic w, input logic [3:0] m,
                        input logic [AW-1:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output logic other);
    logic got;
    wr[n] = w; wmask[n] = m; addr[n] = a; wdata[n] = d; req[n] = 1'b1;
    lat = 0; other = 1'b0; rd = '0; got = 1'b0;
    while (!got && lat < 10) begin
      tick();
      lat++;
      if ((n == 0) ? ack1 : ack0) other = 1'b1;
      if ((n == 0) ? ack0 : ack1) begin
        got = 1'b1;
        rd  = (n == 0) ? rdata0 : rdata1;
      end
    end
    req[n] = 1'b0;
    tick();
  endtask

  task automatic agent(input int n, input int ntx);
    int            idle;
    int            waitc;
    logic          got;
    logic          w;
    logic [3:0]    m;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [31:0]   exp_rd;
    for (int t = 0; t < ntx; t++) begin
      idle = int'($urandom_range(0, 3));
      for (int i = 0; i < idle; i++) begin
        tick();
        chk($sformatf("agent%0d_idle_ack", n), 32'((n == 0) ? ack0 : ack1), 32'd0);
      end
      w = 1'($urandom_range(0, 1));
      m = 4'($urandom);
      a = AW'($urandom_range(0, 15));
      d = $urandom;
      wr[n] = w; wmask[n] = m; addr[n] = a; wdata[n] = d; req[n] = 1'b1;
      got = 1'b0;
      waitc = 0;
      while (!got && waitc < 8) begin
        tick();
        waitc++;
        got = (n == 0) ? ack0 : ack1;
      end
      if (got) begin
        exp_rd = sm[a];
        chk($sformatf("agent%0d_rdata", n), (n == 0) ? rdata0 : rdata1, exp_rd);
        if (w) begin
          for (int k = 0; k < 4; k++) begin
            if (m[k]) sm[a][8*k +: 8] = d[8*k +: 8];
          end
        end
      end else begin
        checks++;
        errors++;
        $display("FAIL agent%0d_timeout: got no ack within %0d cycles, expected ack", n, waitc);
      end
      req[n] = 1'b0;
    end
    if (n == 0) done0 = 1'b1;
    else        done1 = 1'b1;
  endtask

  typedef struct {
    int            port;
    logic          wr;
    logic [3:0]    mask;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp;
  } vec_t;

  vec_t        vt [10];
  logic [31:0] rd;
  int          lat;
  logic        other;
  int          order [4];
  int          when  [4];
  int          nacks;
  int          cyc;
  int          n;
  int          exp_port;

  initial begin
    for (int i = 0; i < 2; i++) begin
      wmask[i] = '0; addr[i] = '0; wdata[i] = '0;
    end
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h005] = 32'hDEADBEEF;
    mem[10'h010] = 32'hAABBCCDD;
    mem[10'h020] = 32'h12345678;
    mem[10'h3FF] = 32'h0BADC0DE;

    vt[0] = '{0, 1'b0, 4'b0000, 10'h005, 32'h0,        32'hDEADBEEF};
    vt[1] = '{1, 1'b1, 4'b0101, 10'h010, 32'h11223344, 32'hAABBCCDD};
    vt[2] = '{1, 1'b0, 4'b0000, 10'h010, 32'h0,        32'hAA22CC44};
    vt[3] = '{0, 1'b1, 4'b1111, 10'h030, 32'hCAFEF00D, 32'h00000000};
    vt[4] = '{1, 1'b0, 4'b0000, 10'h030, 32'h0,        32'hCAFEF00D};
    vt[5] = '{1, 1'b1, 4'b1000, 10'h005, 32'h99000000, 32'hDEADBEEF};
    vt[6] = '{0, 1'b0, 4'b0000, 10'h005, 32'h0,        32'h99ADBEEF};
    vt[7] = '{1, 1'b0, 4'b0000, 10'h3FF, 32'h0,        32'h0BADC0DE};
    vt[8] = '{0, 1'b1, 4'b0000, 10'h3FF, 32'hFFFFFFFF, 32'h0BADC0DE};
    vt[9] = '{0, 1'b0, 4'b0000, 10'h3FF, 32'h0,        32'h0BADC0DE};

    do_reset();

    // Idle bus
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle_c%0d", i), {28'd0, ack0, ack1, busy, ram_wr}, 32'd0);
    end

    // Single transactions from the vector table
    for (int i = 0; i < 10; i++) begin
      do_txn(vt[i].port, vt[i].wr, vt[i].mask, vt[i].addr, vt[i].wdata, rd, lat, other);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_other_ack", i), 32'(other), 32'd0);
    end

    // Simultaneous requests held continuously from reset
    do_reset();
    wr = '0; addr[0] = 10'h005; addr[1] = 10'h010; req = 2'b11;
    nacks = 0; cyc = 0;
    for (int i = 0; i < 4; i++) begin order[i] = 9; when[i] = 0; end
    while (nacks < 4 && cyc < 20) begin
      tick();
      cyc++;
      if (ack0 || ack1) begin
        order[nacks] = ack1 ? 1 : 0;
        when[nacks]  = cyc;
        nacks++;
      end
    end
    req = '0;
    chk("tie_nacks", 32'(nacks), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      exp_port = i % 2;
`else
      exp_port = 1 - (i % 2);
`endif
      chk($sformatf("tie_order%0d", i), 32'(order[i]), 32'(exp_port));
      chk($sformatf("tie_cycle%0d", i), 32'(when[i]), 32'(2 * (i + 1)));
    end
    tick();
    tick();
    chk("tie_idle_after", 32'(busy), 32'd0);

    // Port 0 must not starve behind a continuously requesting port 1
    do_reset();
    wr = '0; addr[0] = 10'h005; addr[1] = 10'h010;
    req[1] = 1'b1;
    tick(); tick(); tick();
    req[0] = 1'b1;
    n = 0;
    while (!ack0 && n < 12) begin
      tick();
      n++;
    end
    req = '0;
    chk("starve_p0_latency_le4", 32'(n <= 4), 32'd1);
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    chk("starve_drain", 32'(busy), 32'd0);

    // Reset during ACCESS of a write
    do_reset();
    wr[1] = 1'b1; wmask[1] = 4'b1111; addr[1] = 10'h020; wdata[1] = 32'hFFFFFFFF;
    req[1] = 1'b1;
    tick();
    chk("rstacc_busy_in_access", 32'(busy), 32'd1);
    rst = 1'b1;
    req[1] = 1'b0;
    #1;
    chk("rstacc_ram_wr_gated", 32'(ram_wr), 32'd0);
    tick();
    chk("rstacc_ack_busy", {30'd0, ack1, busy}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rstacc_no_late_ack", {30'd0, ack0, ack1}, 32'd0);
    chk("rstacc_mem_unchanged", mem[10'h020], 32'h12345678);
    chk("rstacc_idle", 32'(busy), 32'd0);

    // Reset during ACK
    wr[0] = 1'b0; addr[0] = 10'h005; req[0] = 1'b1;
    tick();
    tick();
    chk("rstack_ack_before_rst", 32'(ack0), 32'd1);
    rst = 1'b1;
    req[0] = 1'b0;
    #1;
    chk("rstack_ack_suppressed", 32'(ack0), 32'd0);
    chk("rstack_rdata_zero", rdata0, 32'd0);
    tick();
    rst = 1'b0;
    chk("rstack_idle", 32'(busy), 32'd0);

    // Randomised traffic against a shadow memory
    for (int i = 0; i < 1024; i++) sm[i] = mem[i];
    fork
      agent(0, 150);
      agent(1, 150);
      begin
        while (!(done0 && done1)) begin
          @(negedge clk);
          chk("mon_ack_onehot", 32'(ack0 && ack1), 32'd0);
          chk("mon_no_write_in_ack", 32'(ram_wr && (ack0 || ack1)), 32'd0);
          chk("mon_ack_implies_busy", 32'((ack0 || ack1) && !busy), 32'd0);
        end
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that time-shares the single-port, byte-maskable, 1-cycle-read-latency `ram` between two requesters (port 0: instruction fetch, port 1: load/store unit). It serialises accesses, drives the RAM's `wr`/`wr_mask`/`addr`/`data_in`, and returns `data_out` with a one-cycle acknowledge per completed access. It sits between the core's memory ports and the on-chip RAM instance.

## Interface
- `ADDR_BITS`, 10, word-address width; must match the RAM instance.
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `pN_req`  input  1  port N (N = 0, 1) requests an access; held high with stable payload until `pN_ack`.
- `pN_wr`  input  1  1 = write, 0 = read.
- `pN_wr_mask`  input  4  byte enables for writes; bit k covers `pN_wdata[8k+:8]`.
- `pN_addr`  input  ADDR_BITS  word address.
- `pN_wdata`  input  32  write data.
- `pN_rdata`  output  32  read data; equals `ram_data_out` while `pN_ack`=1, else 0.
- `pN_ack`  output  1  single-cycle completion pulse.
- `ram_wr`  output  1  to RAM `wr`.
- `ram_wr_mask`  output  4  to RAM `wr_mask`.
- `ram_addr`  output  ADDR_BITS  to RAM `addr`.
- `ram_data_in`  output  32  to RAM `data_in`.
- `ram_data_out`  input  32  from RAM `data_out`.
- `busy`  output  1  1 while state is not IDLE.

## Operation
- States: IDLE, ACCESS, ACK. Registered `owner` (1 bit) selects the port muxed onto all `ram_*` outputs.
- IDLE: if any `pN_req`, arbitrate, latch `owner`, go to ACCESS; else stay.
- ACCESS: `ram_addr`/`ram_data_in`/`ram_wr_mask` = owner's payload; `ram_wr` = owner's `pN_wr`. RAM performs write and/or registers read at end of cycle. Always go to ACK.
- ACK: `p[owner]_ack`=1, `p[owner]_rdata`=`ram_data_out`; `ram_wr`=0. Arbitrate among requests with the current owner masked (its `req` is still high this cycle); if a winner exists, latch it and go to ACCESS, else IDLE.
- Writes: ack'd rdata is the pre-write word (RAM read-before-write); masked-off bytes unchanged.
- Arbitration with one requester: that requester wins. With both: per Configuration.
- `ram_wr` is 0 in IDLE and ACK and whenever `rst`=1.

## Timing
- Reset values: state IDLE, `owner`=0, RR pointer=0, all `pN_ack`=0, `pN_rdata`=0, `ram_wr`=0, `busy`=0, `ram_addr`/`ram_data_in`/`ram_wr_mask` = port 0 payload (don't care, write disabled).
- Latency: req seen in IDLE at cycle T -> ACCESS at T+1 -> ack at T+2.
- Throughput: back-to-back alternating ports, one access per 2 cycles (ACK->ACCESS). Same port re-requesting after its ack: seen in IDLE/ACK next, so minimum 3-cycle spacing for a lone port.
- Requester must deassert `req` (or present a new request) the cycle after `ack`; dropping `req` before `ack` is illegal.
- `rst` during ACCESS: write suppressed, no ack, next state IDLE; requester reissues. `rst` during ACK: ack suppressed.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined: round-robin; pointer names the favoured port on a tie and flips to the other port on every grant.
- Undefined: fixed priority, port 1 (data) always wins ties; pointer logic absent.

## Structure
- Package `ram_arb_pkg`: `ram_arb_state_t` enum {IDLE, ACCESS, ACK}; constants `PORT_IFETCH`=0, `PORT_DATA`=1, `NUM_PORTS`=2.
- Sub-module `rr_arbiter2`: combinational grant from 2-bit request + mask + pointer, registered pointer update; `RAM_ARB_ROUND_ROBIN_EN` handled inside it.

## Test plan
- Port 0 read addr 0x005 (RAM preloaded 0xDEADBEEF), port 1 idle -> `p0_ack` at T+2 with `p0_rdata`=0xDEADBEEF, `p1_ack` stays 0.
- Port 1 write 0x11223344 mask 4'b0101 to addr 0x010 holding 0xAABBCCDD, then read -> write ack rdata 0xAABBCCDD; read returns 0xAA22CC44.
- Both request at same cycle from reset, held continuously (RR build) -> grants 0,1,0,1 with acks every 2 cycles; fixed-priority build -> port 1 acked first, port 0 acked next.
- Port 1 continuously re-requesting while port 0 waits (RR build) -> port 0 acked within 4 cycles of its req.
- `rst` asserted during ACCESS of a write to addr 0x020 -> no ack, RAM word unchanged, state IDLE, `busy`=0 next cycle.
- Idle bus: no requests for 10 cycles -> `ram_wr`=0, `busy`=0, all acks 0 throughout.
